ucaspian_synapse: RTL and testbench

UCASPIAN_SYNAPSE -- requirements
Module: ucaspian_synapse

---
 rtl/ucaspian_synapse.sv | 166 ++++++++++++++++
 tb/tb_ucaspian_synapse.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucaspian_synapse.sv
// Synapse RAM stage: streams an inclusive synapse range from a 4096x16 RAM through a 4-entry FIFO to the dendrite port.
// Optional build macro UCASPIAN_SYN_ZERO_SKIP_EN drops zero-weight synapses before they reach the FIFO.
module ucaspian_synapse (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_act,
  input  logic        clear_config,
  output logic        clear_done,
  input  logic [11:0] config_addr,
  input  logic [7:0]  config_value,
  input  logic [2:0]  config_byte,
  input  logic        config_enable,
  input  logic        next_step,
  output logic        step_done,
  input  logic [11:0] syn_start,
  input  logic [11:0] syn_end,
  input  logic        syn_vld,
  output logic        syn_rdy,
  output logic [7:0]  dendrite_addr,
  output logic [7:0]  dendrite_weight,
  output logic        dendrite_vld,
  input  logic        dendrite_rdy
);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;
  state_t state;

  logic [15:0] mem [0:4095];
  logic [15:0] ram_q;
  logic        ram_we;
  logic [11:0] ram_wa;
  logic [15:0] ram_wd;

  logic [12:0] idx, limit;
  logic [11:0] rd_addr_q;
  logic        rd_v1, rd_v2;
  logic [2:0]  in_flight;

  logic [15:0] fifo [0:3];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;

  logic [7:0]  target_q;
  logic [11:0] clr_addr;
  logic        clr_fin;
  logic        act_q;
  logic        issue, push, pop;

  // next_step is a pure timestep marker; in-flight work is unaffected by it
  logic unused_next_step;
  assign unused_next_step = next_step;

  assign in_flight = {2'b0, rd_v1} + {2'b0, rd_v2};
  assign issue = (state == RUN) && enable && !clear_act && !clear_config &&
                 (idx <= limit) && ((count + in_flight) < 3'd4);
`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
  assign push = rd_v2 && (ram_q[7:0] != '0);
`else
  assign push = rd_v2;
`endif
  assign pop = (count != '0) && dendrite_rdy;

  assign dendrite_vld    = (count != '0);
  assign dendrite_addr   = dendrite_vld ? fifo[rd_ptr][15:8] : '0;
  assign dendrite_weight = dendrite_vld ? fifo[rd_ptr][7:0]  : '0;
  assign syn_rdy = (state == IDLE) && !clear_act && !clear_config && !reset;

  always_comb begin
    ram_we = 1'b0;
    ram_wa = config_addr;
    ram_wd = {target_q, config_value};
    if (!reset) begin
      if (state == CLEAR && clear_config && !clr_fin) begin
        ram_we = 1'b1;
        ram_wa = clr_addr;
        ram_wd = '0;
      end else if (config_enable && !clear_config && config_byte == 3'd2) begin
        ram_we = 1'b1;
      end
    end
  end

  // Read uses the pre-write contents on a same-address collision
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    ram_q <= mem[rd_addr_q];
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= ram_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      limit      <= '0;
      rd_addr_q  <= '0;
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      target_q   <= '0;
      clr_addr   <= '0;
      clr_fin    <= 1'b0;
      act_q      <= 1'b0;
      clear_done <= 1'b0;
      step_done  <= 1'b0;
    end else begin
      act_q      <= clear_act;
      clear_done <= (state == CLEAR && clear_config && (clr_fin || clr_addr == 12'hFFF)) ||
                    (act_q && clear_act);
      step_done  <= (state == IDLE) && (count == '0) && !rd_v1 && !rd_v2 &&
                    !syn_vld && !clear_act && !clear_config;
      if (config_enable && !clear_config && config_byte == 3'd1) target_q <= config_value;

      rd_v1 <= issue;
      rd_v2 <= rd_v1;
      if (issue) begin
        rd_addr_q <= idx[11:0];
        idx       <= idx + 13'd1;
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};

      case (state)
        IDLE: if (syn_vld && syn_rdy) begin
          state <= RUN;
          idx   <= {1'b0, syn_start};
          limit <= {1'b0, syn_end};
        end
        RUN: if ((idx > limit) || (issue && idx == limit)) state <= IDLE;
        CLEAR: begin
          if (!clear_config) state <= IDLE;
          else if (!clr_fin) begin
            if (clr_addr == 12'hFFF) clr_fin <= 1'b1;
            else clr_addr <= clr_addr + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Either clear overrides the datapath updates above: pipeline and FIFO are discarded
      if (clear_config || clear_act) begin
        rd_v1  <= 1'b0;
        rd_v2  <= 1'b0;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      if (clear_config) begin
        state <= CLEAR;
        if (state != CLEAR) begin
          clr_addr <= '0;
          clr_fin  <= 1'b0;
        end
      end else if (clear_act) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ucaspian_synapse.sv
// Self-checking bench for ucaspian_synapse against a RAM-array / expected-queue reference model.
module tb_ucaspian_synapse;
  logic        clk = 1'b0;
  logic        reset, enable, clear_act, clear_config, clear_done;
  logic [11:0] config_addr;
  logic [7:0]  config_value;
  logic [2:0]  config_byte;
  logic        config_enable, next_step, step_done;
  logic [11:0] syn_start, syn_end;
  logic        syn_vld, syn_rdy;
  logic [7:0]  dendrite_addr, dendrite_weight;
  logic        dendrite_vld, dendrite_rdy;

  always #5 clk = ~clk;

  ucaspian_synapse dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_act(clear_act),
    .clear_config(clear_config), .clear_done(clear_done),
    .config_addr(config_addr), .config_value(config_value),
    .config_byte(config_byte), .config_enable(config_enable),
    .next_step(next_step), .step_done(step_done),
    .syn_start(syn_start), .syn_end(syn_end), .syn_vld(syn_vld), .syn_rdy(syn_rdy),
    .dendrite_addr(dendrite_addr), .dendrite_weight(dendrite_weight),
    .dendrite_vld(dendrite_vld), .dendrite_rdy(dendrite_rdy)
  );

  logic [15:0] ref_mem [0:4095];
  logic [15:0] expq [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic cfg_write(input int a, input logic [7:0] tgt, input logic [7:0] w);
    config_enable = 1'b1; config_byte = 3'd1; config_value = tgt;
    @(negedge clk);
    config_byte = 3'd2; config_addr = a[11:0]; config_value = w;
    @(negedge clk);
    config_enable = 1'b0; config_byte = 3'd0;
    ref_mem[a] = {tgt, w};
  endtask

  task automatic build_expected(input int s, input int e);
    expq.delete();
    for (int i = s; i <= e; i++) begin
`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
      if (ref_mem[i][7:0] == 8'd0) continue;
`endif
      expq.push_back(ref_mem[i]);
    end
  endtask

  // Drives one range; mode 0 = always ready, 3 = ready 1-of-3, else random ready
  task automatic run_range(input int s, input int e, input int mode,
                           output int n_out, output int first_k, output int last_k, output int rdy_k);
    bit hold, rdy, done;
    logic [15:0] held, exp_w;
    build_expected(s, e);
    n_out = 0; first_k = -1; last_k = -1; rdy_k = -1; hold = 0; done = 0; held = '0;
    n_tests++;
    if (syn_rdy !== 1'b1) begin
      n_fail++; $display("FAIL syn_rdy_before_range: got %b expected 1", syn_rdy);
    end
    syn_start = s[11:0]; syn_end = e[11:0]; syn_vld = 1'b1;
    @(negedge clk);
    syn_vld = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (syn_rdy && rdy_k < 0) rdy_k = k;
      if (hold) begin
        n_tests++;
        if (dendrite_vld !== 1'b1 || {dendrite_addr, dendrite_weight} !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got vld=%b data=%h expected vld=1 data=%h",
                   dendrite_vld, {dendrite_addr, dendrite_weight}, held);
        end
      end
      case (mode)
        0: rdy = 1'b1;
        3: rdy = (k % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (dendrite_vld === 1'b1) begin
        if (first_k < 0) first_k = k;
        if (rdy) begin
          n_tests++;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL extra_output: got %h expected none", {dendrite_addr, dendrite_weight});
          end else begin
            exp_w = expq.pop_front();
            if ({dendrite_addr, dendrite_weight} !== exp_w) begin
              n_fail++;
              $display("FAIL output_data: got %h expected %h", {dendrite_addr, dendrite_weight}, exp_w);
            end
          end
          n_out++; last_k = k;
        end
      end
      hold = (dendrite_vld === 1'b1) && !rdy;
      held = {dendrite_addr, dendrite_weight};
      dendrite_rdy = rdy;
      if (expq.size() == 0 && dendrite_vld !== 1'b1 && syn_rdy === 1'b1) done = 1;
      else @(negedge clk);
    end
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL range_timeout: got %0d pending expected 0", expq.size());
    end
    dendrite_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_tests++;
      if (dendrite_vld !== 1'b0) begin
        n_fail++; $display("FAIL trailing_output: got vld=%b expected 0", dendrite_vld);
      end
    end
    n_tests++;
    if (step_done !== 1'b1) begin
      n_fail++; $display("FAIL step_done_after: got %b expected 1", step_done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({dendrite_vld, dendrite_addr, dendrite_weight, clear_done, step_done, syn_rdy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b a=%h w=%h cd=%b sd=%b rdy=%b expected all 0",
               dendrite_vld, dendrite_addr, dendrite_weight, clear_done, step_done, syn_rdy);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (syn_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rdy_after_reset: got %b expected 1", syn_rdy);
    end
  endtask

  task automatic preload;
    for (int n = 0; n < 4; n++) cfg_write(16'h010 + n, 8'(n), 8'(8'h05 + n));
    for (int a = 16'h020; a <= 16'h027; a++) cfg_write(a, 8'($urandom), 8'($urandom));
    cfg_write(12'hFFE, 8'($urandom), 8'($urandom));
    cfg_write(12'hFFF, 8'($urandom), 8'($urandom));
    cfg_write(12'h100, 8'($urandom), 8'd3);
    cfg_write(12'h101, 8'($urandom), 8'd0);
    cfg_write(12'h102, 8'($urandom), 8'd0);
    cfg_write(12'h103, 8'($urandom), 8'd7);
    for (int a = 16'h200; a <= 16'h2FF; a++) cfg_write(a, 8'($urandom), 8'($urandom));
  endtask

  task automatic test_basic;
    int n, f, l, r;
    run_range(12'h010, 12'h013, 0, n, f, l, r);
    n_tests++;
    if (n != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", n); end
    n_tests++;
    if (f != 3) begin n_fail++; $display("FAIL first_latency: got %0d expected 3", f); end
    n_tests++;
    if (l - f != 3) begin n_fail++; $display("FAIL back_to_back: got span %0d expected 3", l - f); end
  endtask

  task automatic test_stall;
    int n, f, l, r;
    run_range(12'h020, 12'h027, 3, n, f, l, r);
    n_tests++;
    if (n != 8) begin n_fail++; $display("FAIL stall_count: got %0d expected 8", n); end
  endtask

  task automatic test_boundaries;
    int n, f, l, r;
    run_range(12'hFFE, 12'hFFF, 0, n, f, l, r);
    n_tests++;
    if (n != 2) begin n_fail++; $display("FAIL top_range_count: got %0d expected 2", n); end
    run_range(12'h050, 12'h04F, 0, n, f, l, r);
    n_tests++;
    if (n != 0) begin n_fail++; $display("FAIL empty_range_count: got %0d expected 0", n); end
    n_tests++;
    if (r != 1) begin n_fail++; $display("FAIL empty_range_rdy: got cycle %0d expected 1", r); end
  endtask

  task automatic test_zero_skip;
    int n, f, l, r, expn;
`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
    expn = 2;
`else
    expn = 4;
`endif
    run_range(12'h100, 12'h103, 0, n, f, l, r);
    n_tests++;
    if (n != expn) begin n_fail++; $display("FAIL zero_skip_count: got %0d expected %0d", n, expn); end
  endtask

  task automatic test_random;
    int n, f, l, r, s, len;
    for (int t = 0; t < 4; t++) begin
      s = 16'h200 + $urandom_range(0, 200);
      len = $urandom_range(0, 40);
      run_range(s, s + len, 99, n, f, l, r);
    end
  endtask

  task automatic test_clear_act;
    syn_start = 12'h200; syn_end = 12'h2FF; syn_vld = 1'b1; dendrite_rdy = 1'b1;
    @(negedge clk);
    syn_vld = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (dendrite_vld !== 1'b1) begin n_fail++; $display("FAIL act_running: got %b expected 1", dendrite_vld); end
    clear_act = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dendrite_vld !== 1'b0 || clear_done !== 1'b0) begin
      n_fail++; $display("FAIL act_flush: got vld=%b cd=%b expected 0 0", dendrite_vld, clear_done);
    end
    @(negedge clk);
    n_tests++;
    if (clear_done !== 1'b1 || syn_rdy !== 1'b0) begin
      n_fail++; $display("FAIL act_done: got cd=%b rdy=%b expected 1 0", clear_done, syn_rdy);
    end
    clear_act = 1'b0;
    #1;
    n_tests++;
    if (syn_rdy !== 1'b1) begin n_fail++; $display("FAIL act_rdy_release: got %b expected 1", syn_rdy); end
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if (dendrite_vld !== 1'b0) begin n_fail++; $display("FAIL act_no_output: got %b expected 0", dendrite_vld); end
    end
  endtask

  task automatic test_reset_midrun;
    syn_start = 12'h200; syn_end = 12'h2FF; syn_vld = 1'b1; dendrite_rdy = 1'b1;
    @(negedge clk);
    syn_vld = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_tests++;
      if (dendrite_vld !== 1'b0 || syn_rdy !== 1'b1) begin
        n_fail++; $display("FAIL reset_midrun: got vld=%b rdy=%b expected 0 1", dendrite_vld, syn_rdy);
      end
    end
  endtask

  task automatic test_clear_config;
    int n, f, l, r, cyc;
    clear_config = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (clear_done !== 1'b1 && cyc < 5000);
    n_tests++;
    if (cyc != 4097) begin n_fail++; $display("FAIL clear_done_cycle: got %0d expected 4097", cyc); end
    @(negedge clk);
    n_tests++;
    if (clear_done !== 1'b1) begin n_fail++; $display("FAIL clear_done_held: got %b expected 1", clear_done); end
    clear_config = 1'b0;
    for (int a = 0; a < 4096; a++) ref_mem[a] = '0;
    @(negedge clk);
    n_tests++;
    if (clear_done !== 1'b0 || syn_rdy !== 1'b1) begin
      n_fail++; $display("FAIL clear_release: got cd=%b rdy=%b expected 0 1", clear_done, syn_rdy);
    end
    run_range(12'h000, 12'h003, 0, n, f, l, r);
    n_tests++;
`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
    if (n != 0) begin n_fail++; $display("FAIL cleared_count: got %0d expected 0", n); end
`else
    if (n != 4) begin n_fail++; $display("FAIL cleared_count: got %0d expected 4", n); end
`endif
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear_act = 1'b0; clear_config = 1'b0;
    config_addr = '0; config_value = '0; config_byte = '0; config_enable = 1'b0;
    next_step = 1'b0; syn_start = '0; syn_end = '0; syn_vld = 1'b0; dendrite_rdy = 1'b1;
    for (int a = 0; a < 4096; a++) ref_mem[a] = 'x;
    @(negedge clk);
    test_reset;
    preload;
    test_basic;
    test_stall;
    test_boundaries;
    test_zero_skip;
    test_random;
    test_clear_act;
    test_reset_midrun;
    test_clear_config;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
